// File: rtl/node_pkg.sv
// Shared types and elaboration helpers for the neuron node family.
package node_pkg;

  typedef enum logic [1:0] {ST_ACC, ST_FIN, ST_OUT} state_e;

  // Smallest accumulator that cannot overflow: full product plus growth over N_IN terms and bias.
  function automatic int min_acc_w(input int n_in, input int data_w, input int w_w);
    return data_w + w_w + $clog2(n_in + 1);
  endfunction

endpackage

// File: rtl/node_mac_seq_if.sv
// Streaming activation / result / weight-load bundle for node_mac_seq.
interface node_mac_seq_if #(
  parameter int N_IN   = 15,
  parameter int DATA_W = 8,
  parameter int W_W    = 8,
  parameter int OUT_W  = 8
);
  localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic              wt_we;
  logic [AW-1:0]     wt_addr;
  logic [W_W-1:0]    wt_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              frame_err;

  modport master (
    output wt_we, wt_addr, wt_data, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, frame_err
  );

  modport slave (
    input  wt_we, wt_addr, wt_data, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, frame_err
  );
endinterface

// File: rtl/node_round_sat.sv
// Accumulator to output conversion: drop FRAC bits, round above half, then clamp
// (ReLU range or signed range) at full width so a rounded overflow clips instead of wrapping.
module node_round_sat #(
  parameter int ACC_W = 23,
  parameter int FRAC  = 6,
  parameter int OUT_W = 8,
  parameter int RELU  = 1
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] res
);
  localparam int MAXI = (1 << (OUT_W - 1)) - 1;
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(MAXI);
  localparam logic signed [ACC_W-1:0] MINV = (RELU != 0) ? '0 : ACC_W'(-MAXI - 1);
  localparam logic [FRAC-1:0] HALF = FRAC'(1 << (FRAC - 1));

  logic signed [ACC_W-1:0] q, qr;
  logic [FRAC-1:0]         r;
  logic                    inc;

  always_comb begin
    q   = acc >>> FRAC;
    r   = acc[FRAC-1:0];
    // exact half truncates; only strictly-above-half rounds up
    inc = (r > HALF);
    qr  = q + ACC_W'(inc);
    if (qr > MAXV)      res = MAXV[OUT_W-1:0];
    else if (qr < MINV) res = MINV[OUT_W-1:0];
    else                res = qr[OUT_W-1:0];
  end
endmodule

// File: rtl/node_mac_seq.sv
// One neuron per frame through a single MAC: N_IN accumulate beats, one rounding
// cycle, then the result is held until the consumer takes it.
module node_mac_seq
  import node_pkg::*;
#(
  parameter int N_IN   = 15,
  parameter int DATA_W = 8,
  parameter int W_W    = 8,
  parameter int ACC_W  = 23,
  parameter int FRAC   = 6,
  parameter int OUT_W  = 8,
  parameter int BIAS   = 512,
  parameter int RELU   = 1
) (
  input logic            clk,
  input logic            reset,
  node_mac_seq_if.slave  bus
);
  localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int PW = DATA_W + W_W;

  if (ACC_W < min_acc_w(N_IN, DATA_W, W_W)) begin : g_acc_w_chk
    $error("node_mac_seq: ACC_W below minimum for N_IN/DATA_W/W_W");
  end

  state_e                   state, state_nxt;
  logic [AW-1:0]            cnt;
  logic signed [ACC_W-1:0]  acc;
  logic [N_IN-1:0][W_W-1:0] wt;
  logic                     rdy_q, ferr_q;
  logic [OUT_W-1:0]         out_q;
  logic                     beat, last_idx;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [OUT_W-1:0]  res;

  // rdy_q keeps in_ready low through reset and until the first clock after release
  assign bus.in_ready  = rdy_q && (state == ST_ACC);
  assign bus.out_valid = (state == ST_OUT);
  assign bus.out_data  = out_q;
  assign bus.frame_err = ferr_q;

  assign beat     = bus.in_valid && bus.in_ready;
  assign last_idx = (cnt == AW'(N_IN - 1));
  assign prod     = PW'($signed(bus.in_data)) * PW'($signed(wt[cnt]));
  assign prod_ext = {{(ACC_W - PW){prod[PW-1]}}, prod};

  node_round_sat #(.ACC_W(ACC_W), .FRAC(FRAC), .OUT_W(OUT_W), .RELU(RELU)) u_round_sat (
    .acc (acc),
    .res (res)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_ACC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACC:  if (beat && last_idx) state_nxt = ST_FIN;
      ST_FIN:  state_nxt = ST_OUT;
      ST_OUT:  if (bus.out_ready) state_nxt = ST_ACC;
      default: state_nxt = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      acc    <= ACC_W'(BIAS);
      wt     <= '0;
      rdy_q  <= 1'b0;
      ferr_q <= 1'b0;
      out_q  <= '0;
    end else begin
      rdy_q  <= 1'b1;
      // frame length comes from cnt; in_last is only cross-checked
      ferr_q <= beat && (bus.in_last != last_idx);
      if (bus.wt_we && ({1'b0, bus.wt_addr} < (AW + 1)'(N_IN)))
        wt[bus.wt_addr] <= bus.wt_data;
      if (beat) begin
        acc <= acc + prod_ext;
        cnt <= last_idx ? '0 : cnt + AW'(1);
      end
      if (state == ST_FIN)
        out_q <= res;
      if (state == ST_OUT && bus.out_ready)
        acc <= ACC_W'(BIAS);
    end
  end
endmodule

// File: tb/tb_node_mac_seq.sv
// Directed bench: ReLU and linear instances driven in lockstep, results checked against a scoreboard.
module tb_node_mac_seq;
  localparam int N = 15, DW = 8, WW = 8, AW = 4, OW = 8, BIAS = 512;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          wt_we = 1'b0;
  logic [AW-1:0] wt_addr = '0;
  logic [WW-1:0] wt_data = '0;
  logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;

  node_mac_seq_if #(.N_IN(N), .DATA_W(DW), .W_W(WW), .OUT_W(OW)) if_r ();
  node_mac_seq_if #(.N_IN(N), .DATA_W(DW), .W_W(WW), .OUT_W(OW)) if_l ();

  assign if_r.wt_we = wt_we;       assign if_l.wt_we = wt_we;
  assign if_r.wt_addr = wt_addr;   assign if_l.wt_addr = wt_addr;
  assign if_r.wt_data = wt_data;   assign if_l.wt_data = wt_data;
  assign if_r.in_valid = in_valid; assign if_l.in_valid = in_valid;
  assign if_r.in_data = in_data;   assign if_l.in_data = in_data;
  assign if_r.in_last = in_last;   assign if_l.in_last = in_last;
  assign if_r.out_ready = out_ready; assign if_l.out_ready = out_ready;

  node_mac_seq #(.N_IN(N), .DATA_W(DW), .W_W(WW), .ACC_W(23), .FRAC(6), .OUT_W(OW),
                 .BIAS(BIAS), .RELU(1)) u_r (.clk(clk), .reset(reset), .bus(if_r));
  node_mac_seq #(.N_IN(N), .DATA_W(DW), .W_W(WW), .ACC_W(23), .FRAC(6), .OUT_W(OW),
                 .BIAS(BIAS), .RELU(0)) u_l (.clk(clk), .reset(reset), .bus(if_l));

  int n_assert = 0, n_fail = 0;
  int wt_m [N];
  int din [N];
  int q_r [$];
  int q_l [$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model(input int relu);
    int acc, q, r;
    acc = BIAS;
    for (int k = 0; k < N; k++) acc += din[k] * wt_m[k];
    q = acc >>> 6;
    r = acc & 63;
    if (r > 32) q++;
    if (q > 127) q = 127;
    if (relu != 0) begin
      if (q < 0) q = 0;
    end else if (q < -128) q = -128;
    return q;
  endfunction

  task automatic wr_wt(input int a, input int v);
    wt_we = 1'b1; wt_addr = AW'(a); wt_data = WW'(v);
    @(posedge clk); #1;
    wt_we = 1'b0;
    if (a < N) wt_m[a] = v;
  endtask

  task automatic set_all(input int w, input int d);
    for (int k = 0; k < N; k++) begin
      wr_wt(k, w);
      din[k] = d;
    end
  endtask

  task automatic clear_din();
    for (int k = 0; k < N; k++) din[k] = 0;
  endtask

  task automatic send_frame(input int last_at, input int nb);
    int g;
    for (int k = 0; k < nb; k++) begin
      in_valid = 1'b1; in_data = DW'(din[k]); in_last = (k == last_at);
      g = 0;
      while (!if_r.in_ready && g < 50) begin @(posedge clk); #1; g++; end
      if (g >= 50) chk("in_ready_wait", int'(if_r.in_ready), 1);
      @(posedge clk); #1;
      chk("frame_err_r", int'(if_r.frame_err), int'((k == last_at) != (k == N - 1)));
      chk("frame_err_l", int'(if_l.frame_err), int'((k == last_at) != (k == N - 1)));
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (nb == N) begin
      q_r.push_back(model(1));
      q_l.push_back(model(0));
    end
  endtask

  task automatic get_result(input string tag, input int hold);
    int g, er, el;
    out_ready = 1'b0;
    g = 0;
    while (!if_r.out_valid && g < 100) begin @(posedge clk); #1; g++; end
    chk({tag, "_valid"}, int'(if_r.out_valid & if_l.out_valid), 1);
    er = (q_r.size() > 0) ? q_r.pop_front() : -999;
    el = (q_l.size() > 0) ? q_l.pop_front() : -999;
    chk({tag, "_relu"}, int'($signed(if_r.out_data)), er);
    chk({tag, "_lin"},  int'($signed(if_l.out_data)), el);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, int'(if_r.out_valid), 1);
      chk({tag, "_hold_data"}, int'($signed(if_r.out_data)), er);
      chk({tag, "_hold_in_ready"}, int'(if_r.in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_released"}, int'(if_r.out_valid), 0);
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin wt_m[k] = 0; din[k] = 0; end

    // reset state
    #12;
    chk("rst_in_ready", int'(if_r.in_ready), 0);
    chk("rst_out_valid", int'(if_r.out_valid), 0);
    chk("rst_out_data", int'(if_r.out_data), 0);
    chk("rst_frame_err", int'(if_r.frame_err), 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", int'(if_r.in_ready), 1);

    // weights all zero: bias only
    for (int k = 0; k < N; k++) din[k] = k * 7 - 50;
    send_frame(14, N);
    get_result("bias_only", 0);

    clear_din();
    wr_wt(15, 99);
    wr_wt(0, 31); din[0] = 10;
    send_frame(14, N);
    get_result("w31_in10", 0);

    wr_wt(0, 1); din[0] = 32;
    send_frame(14, N);
    get_result("half_exact", 0);
    din[0] = 33;
    send_frame(14, N);
    get_result("half_above", 0);

    wr_wt(0, -31); din[0] = 100;
    send_frame(14, N);
    get_result("negative", 0);

    wr_wt(0, 87); din[0] = 88;
    send_frame(14, N);
    get_result("round_overflow", 0);

    set_all(31, 127);
    send_frame(14, N);
    get_result("sat_pos", 0);
    set_all(-31, 127);
    send_frame(14, N);
    get_result("sat_neg", 0);

    // back-pressure, then an early in_last
    set_all(2, 0);
    for (int k = 0; k < N; k++) din[k] = k + 1;
    send_frame(14, N);
    get_result("backpressure", 5);
    send_frame(3, N);
    get_result("early_last", 0);

    // abort a frame with reset after 7 beats
    set_all(-3, 9);
    send_frame(14, 7);
    reset = 1'b0;
    #2;
    chk("midrst_in_ready", int'(if_r.in_ready), 0);
    chk("midrst_out_valid", int'(if_l.out_valid), 0);
    for (int k = 0; k < N; k++) wt_m[k] = 0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    wr_wt(1, 5);
    for (int k = 0; k < N; k++) din[k] = 20;
    send_frame(14, N);
    get_result("after_abort", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
